// File: rtl/uart_mem_responder_pkg.sv
// Shared encodings for the UART monitor memory responder: FSM states and memory target select.
package uart_mem_responder_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADR  = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_RD_RET  = 3'd3;
  localparam logic [2:0] ST_WR      = 3'd4;
  localparam logic [2:0] ST_WR_RET  = 3'd5;
  localparam logic [2:0] ST_RELEASE = 3'd6;

  // Meaning of u_read_w / u_write_w as driven by the UART command decoder.
  localparam logic MEM_SEL_IMEM = 1'b1;
  localparam logic MEM_SEL_DMEM = 1'b0;

endpackage

// File: rtl/uart_mem_responder.sv
// Runs one UART-monitor read/write on imem or dmem while the CPU is halted; read pulse 3 cycles, write pulse 2 cycles after request.
// Requests are levels held until their pulse; cpu_run=1 stalls new requests in IDLE only.
module uart_mem_responder
  import uart_mem_responder_pkg::*;
#(
  parameter int IWIDTH = 14,
  parameter int DWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              u_read_req,
  input  logic              u_read_w,
  input  logic [31:0]       u_read_adr,
  output logic              read_valid,
  output logic [31:0]       read_data,
  input  logic              u_write_req,
  input  logic              u_write_w,
  input  logic [31:0]       u_write_adr,
  input  logic [31:0]       u_write_data,
  output logic              write_finish,
  input  logic              cpu_run,
  output logic              mon_busy,
  output logic [IWIDTH-1:0] i_adr,
  output logic              i_re,
  output logic              i_we,
  output logic [31:0]       i_wdata,
  input  logic [31:0]       i_rdata,
  output logic [DWIDTH-1:0] d_adr,
  output logic              d_re,
  output logic              d_we,
  output logic [31:0]       d_wdata,
  input  logic [31:0]       d_rdata
);

  logic [2:0] r_state;
  logic       r_sel;

  // Write wins when both requests are raised together.
  wire        w_wr_go  = !cpu_run && u_write_req;
  wire        w_rd_go  = !cpu_run && u_read_req && !u_write_req;
  wire        w_go_sel = u_write_req ? u_write_w : u_read_w;
  wire [31:0] w_go_adr = u_write_req ? u_write_adr : u_read_adr;

  // Byte-lane bits and bits above the memory depth are dropped on purpose.
  wire        w_unused_adr_bits = ^{u_read_adr, u_write_adr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= MEM_SEL_DMEM;
      read_valid   <= 1'b0;
      read_data    <= '0;
      write_finish <= 1'b0;
      mon_busy     <= 1'b0;
      i_adr        <= '0;
      i_re         <= 1'b0;
      i_we         <= 1'b0;
      i_wdata      <= '0;
      d_adr        <= '0;
      d_re         <= 1'b0;
      d_we         <= 1'b0;
      d_wdata      <= '0;
    end else begin
      i_re         <= 1'b0;
      i_we         <= 1'b0;
      d_re         <= 1'b0;
      d_we         <= 1'b0;
      read_valid   <= 1'b0;
      write_finish <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_wr_go || w_rd_go) begin
            r_sel    <= w_go_sel;
            mon_busy <= 1'b1;
            r_state  <= w_wr_go ? ST_WR : ST_RD_ADR;
            if (w_go_sel == MEM_SEL_IMEM) begin
              i_adr <= w_go_adr[IWIDTH+1:2];
              i_re  <= w_rd_go;
              i_we  <= w_wr_go;
              if (w_wr_go) i_wdata <= u_write_data;
            end else begin
              d_adr <= w_go_adr[DWIDTH+1:2];
              d_re  <= w_rd_go;
              d_we  <= w_wr_go;
              if (w_wr_go) d_wdata <= u_write_data;
            end
          end
        end
        ST_RD_ADR: r_state <= ST_RD_DATA;
        ST_RD_DATA: begin
          read_data  <= (r_sel == MEM_SEL_IMEM) ? i_rdata : d_rdata;
          read_valid <= 1'b1;
          r_state    <= ST_RD_RET;
        end
        ST_RD_RET: r_state <= ST_RELEASE;
        ST_WR: begin
          write_finish <= 1'b1;
          r_state      <= ST_WR_RET;
        end
        ST_WR_RET: r_state <= ST_RELEASE;
        ST_RELEASE: begin
          // A request still held from the finished access must not restart it.
          if (!u_read_req && !u_write_req) begin
            mon_busy <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          mon_busy <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_responder.sv
// Bench for uart_mem_responder: vector table, corner sequences and random accesses against a word-array reference model.
module tb_uart_mem_responder;

  localparam int W = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          u_read_req = 1'b0, u_read_w = 1'b0;
  logic [31:0]   u_read_adr = '0;
  logic          read_valid;
  logic [31:0]   read_data;
  logic          u_write_req = 1'b0, u_write_w = 1'b0;
  logic [31:0]   u_write_adr = '0, u_write_data = '0;
  logic          write_finish;
  logic          cpu_run = 1'b0;
  logic          mon_busy;
  logic [W-1:0]  i_adr, d_adr;
  logic          i_re, i_we, d_re, d_we;
  logic [31:0]   i_wdata, d_wdata;
  logic [31:0]   i_rdata = '0, d_rdata = '0;

  uart_mem_responder #(.IWIDTH(W), .DWIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .u_read_req(u_read_req), .u_read_w(u_read_w), .u_read_adr(u_read_adr),
    .read_valid(read_valid), .read_data(read_data),
    .u_write_req(u_write_req), .u_write_w(u_write_w), .u_write_adr(u_write_adr),
    .u_write_data(u_write_data), .write_finish(write_finish),
    .cpu_run(cpu_run), .mon_busy(mon_busy),
    .i_adr(i_adr), .i_re(i_re), .i_we(i_we), .i_wdata(i_wdata), .i_rdata(i_rdata),
    .d_adr(d_adr), .d_re(d_re), .d_we(d_we), .d_wdata(d_wdata), .d_rdata(d_rdata)
  );

  always #5 clk = ~clk;

  // SRAMs seen by the DUT
  bit [31:0] imem [0:(1<<W)-1];
  bit [31:0] dmem [0:(1<<W)-1];
  always @(posedge clk) begin
    if (i_we) imem[i_adr] <= i_wdata;
    if (i_re) i_rdata <= imem[i_adr];
    if (d_we) dmem[d_adr] <= d_wdata;
    if (d_re) d_rdata <= dmem[d_adr];
  end

  // Reference contents, indexed by word = (byte address / 4) mod depth
  bit [31:0] ref_i [0:(1<<W)-1];
  bit [31:0] ref_d [0:(1<<W)-1];

  int total = 0;
  int bad = 0;
  int viol = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % (32'd1 << W));
  endfunction

  // Port rules that must hold on every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((i_re && i_we) || (d_re && d_we) || ((i_re || i_we) && (d_re || d_we)) ||
          (!mon_busy && (i_re || i_we || d_re || d_we)))
        viol++;
    end
  end

  task automatic issue(input bit wr, input bit sel, input logic [31:0] adr, input logic [31:0] wd);
    if (wr) begin
      u_write_req = 1'b1; u_write_w = sel; u_write_adr = adr; u_write_data = wd;
    end else begin
      u_read_req = 1'b1; u_read_w = sel; u_read_adr = adr;
    end
  endtask

  task automatic finish_access(input bit wr, input bit sel, input logic [31:0] adr,
                               input logic [31:0] wd, input logic [31:0] exp_rd,
                               input bit bump_run, input string nm);
    int lat = 0, tgt_en = 0, oth_en = 0, busy_wait = 0;
    logic [31:0] adr_seen = '1, wd_seen = '0;
    logic        we_seen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1 && bump_run) cpu_run = 1'b1;
      if (sel ? (i_re || i_we) : (d_re || d_we)) begin
        tgt_en++;
        adr_seen = sel ? 32'(i_adr) : 32'(d_adr);
        wd_seen  = sel ? i_wdata : d_wdata;
        we_seen  = sel ? i_we : d_we;
      end
      if (sel ? (d_re || d_we) : (i_re || i_we)) oth_en++;
      if ((wr && write_finish) || (!wr && read_valid)) begin
        lat = k;
        break;
      end
    end
    check({nm, " latency"}, 32'(lat), wr ? 32'd2 : 32'd3);
    check({nm, " enable cycles"}, 32'(tgt_en), 32'd1);
    check({nm, " other mem idle"}, 32'(oth_en), 32'd0);
    check({nm, " word adr"}, adr_seen, 32'(widx(adr)));
    check({nm, " enable kind"}, 32'(we_seen), 32'(wr));
    if (wr) check({nm, " wdata"}, wd_seen, wd);
    else    check({nm, " rdata"}, read_data, exp_rd);
    u_write_req = 1'b0;
    u_read_req  = 1'b0;
    @(negedge clk);
    check({nm, " pulse width"}, 32'(wr ? write_finish : read_valid), 32'd0);
    if (!wr) check({nm, " rdata held"}, read_data, exp_rd);
    while (mon_busy && busy_wait < 6) begin
      @(negedge clk);
      busy_wait++;
    end
    check({nm, " released"}, 32'(mon_busy), 32'd0);
    cpu_run = 1'b0;
  endtask

  task automatic run_vec(input bit wr, input bit sel, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input bit bump_run, input string nm);
    issue(wr, sel, adr, wd);
    finish_access(wr, sel, adr, wd, exp_rd, bump_run, nm);
    if (wr) begin
      if (sel) ref_i[widx(adr)] = wd;
      else     ref_d[widx(adr)] = wd;
    end
  endtask

  typedef struct {
    bit          wr;
    bit          sel;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int cnt_a, cnt_b, cnt_c;
    tbl[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         32'h1234_5678};
    tbl[3] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    tbl[4] = '{1'b0, 1'b1, 32'h0001_0023, 32'h0,         32'h1234_5678};
    tbl[5] = '{1'b1, 1'b1, 32'h0001_0007, 32'hCAFE_F00D, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,         32'hCAFE_F00D};
    tbl[7] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h0};
    tbl[8] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'h0};
    tbl[9] = '{1'b0, 1'b1, 32'h0001_0004, 32'h0,         32'hCAFE_F00D};

    #2;
    check("reset ctrl", 32'({read_valid, write_finish, mon_busy, i_re, i_we, d_re, d_we}), 32'd0);
    check("reset read_data", read_data, 32'd0);
    check("reset adr", 32'({i_adr, d_adr}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++)
      run_vec(tbl[v].wr, tbl[v].sel, tbl[v].adr, tbl[v].wd, tbl[v].exp_rd, 1'b0, $sformatf("vec%0d", v));

    // Both requests raised together: write first, read only after a release.
    issue(1'b1, 1'b0, 32'h0000_0040, 32'hA5A5_0001);
    issue(1'b0, 1'b1, 32'h0000_0020, 32'h0);
    cnt_a = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (write_finish) begin
        cnt_a = k;
        break;
      end
    end
    check("both: write latency", 32'(cnt_a), 32'd2);
    cnt_b = 0;
    cnt_c = 0;
    repeat (5) begin
      @(negedge clk);
      if (i_re || d_re || read_valid) cnt_b++;
      if (!mon_busy) cnt_c++;
    end
    check("both: no retrigger", 32'(cnt_b), 32'd0);
    check("both: held busy", 32'(cnt_c), 32'd0);
    ref_d[widx(32'h40)] = 32'hA5A5_0001;
    u_write_req = 1'b0;
    u_read_req  = 1'b0;
    repeat (2) @(negedge clk);
    check("both: released", 32'(mon_busy), 32'd0);
    run_vec(1'b0, 1'b1, 32'h0000_0020, 32'h0, ref_i[widx(32'h20)], 1'b0, "both: read after");
    run_vec(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_0001, 1'b0, "both: write landed");

    // CPU running blocks a held request until it halts.
    cpu_run = 1'b1;
    issue(1'b0, 1'b0, 32'h0000_0040, 32'h0);
    cnt_b = 0;
    repeat (10) begin
      @(negedge clk);
      if (i_re || i_we || d_re || d_we || mon_busy) cnt_b++;
    end
    check("cpu_run stall", 32'(cnt_b), 32'd0);
    cpu_run = 1'b0;
    finish_access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_0001, 1'b0, "cpu_run release");

    // Async reset in the middle of a read.
    issue(1'b0, 1'b1, 32'h0000_0020, 32'h0);
    @(negedge clk);
    check("rst: re before", 32'(i_re), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst: ctrl async", 32'({read_valid, write_finish, mon_busy, i_re, i_we, d_re, d_we}), 32'd0);
    check("rst: read_data", read_data, 32'd0);
    u_read_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt_b = 0;
    repeat (6) begin
      @(negedge clk);
      if (read_valid || mon_busy) cnt_b++;
    end
    check("rst: no stray pulse", 32'(cnt_b), 32'd0);
    run_vec(1'b0, 1'b1, 32'h0000_0020, 32'h0, ref_i[widx(32'h20)], 1'b0, "rst: fresh read");

    // Random traffic against the reference arrays.
    for (int n = 0; n < 60; n++) begin
      bit          wr, sel, bump;
      logic [31:0] adr, wd;
      wr   = 1'($urandom_range(0, 1));
      sel  = 1'($urandom_range(0, 1));
      bump = ($urandom_range(0, 3) == 0);
      adr  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      wd   = $urandom;
      run_vec(wr, sel, adr, wd, sel ? ref_i[widx(adr)] : ref_d[widx(adr)], bump,
              $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("port rule violations", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
